// File: rtl/instr_loader_pkg.sv
// Shared definitions for the MIPS program loader: opcode/funct encodings
// (matching the main decoder), request kind/ALU enums and FSM states.
package instr_loader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        KIND_RTYPE = 3'd0,
        KIND_LW    = 3'd1,
        KIND_SW    = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ADDI  = 3'd4,
        KIND_J     = 3'd5
    } kind_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Map an R-type ALU selector to its funct field; unknown selectors give 0.
    function automatic logic [5:0] alu_funct(input logic [2:0] alu);
        logic [5:0] f;
        case (alu)
            ALU_ADD: f = FUNCT_ADD;
            ALU_SUB: f = FUNCT_SUB;
            ALU_AND: f = FUNCT_AND;
            ALU_OR:  f = FUNCT_OR;
            ALU_SLT: f = FUNCT_SLT;
            default: f = 6'b000000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_loader_pack.sv
// Combinational MIPS encoder: turns one abstract request into a 32-bit word.
// Optional feature macro: INSTR_LOADER_RANGE_CHECK_EN enables the branch /
// jump target range checks reported on range_bad.
module instr_pack
    import instr_loader_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  alu,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] target,
    input  logic [31:0] pc,
    output logic [31:0] word,
    output logic        illegal,
    output logic        range_bad
);

`ifdef INSTR_LOADER_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    logic [31:0]        diff;
    logic signed [31:0] off;
    logic               bad;

    // Encode the request; flag unknown kinds/ALU ops and out-of-range targets.
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        bad     = 1'b0;
        diff    = target - (pc + 32'd4);
        off     = $signed(diff) >>> 2;
        case (kind)
            KIND_RTYPE: begin
                word    = {OP_RTYPE, rs, rt, rd, 5'b00000, alu_funct(alu)};
                illegal = (alu > 3'd4);
            end
            KIND_LW:   word = {OP_LW, rs, rt, imm};
            KIND_SW:   word = {OP_SW, rs, rt, imm};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            KIND_BEQ: begin
                word = {OP_BEQ, rs, rt, off[15:0]};
                // Misaligned target shows up in the low bits of the difference
                // because the next-PC is always word aligned.
                bad  = (diff[1:0] != 2'b00) ||
                       !((off[31:15] == 17'h00000) || (off[31:15] == 17'h1FFFF));
            end
            KIND_J: begin
                word = {OP_J, target[27:2]};
                bad  = (target[1:0] != 2'b00) || (target[31:28] != 4'b0000);
            end
            default: illegal = 1'b1;
        endcase
        range_bad = RANGE_EN & bad;
    end

endmodule

// File: rtl/instr_loader.sv
// Program loader in front of the MIPS instruction memory: accepts requests,
// encodes them and writes consecutive slots, then releases the core.
// Optional feature macro: INSTR_LOADER_RANGE_CHECK_EN (see instr_pack).
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_kind,
    input  logic [2:0]    in_alu,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic [31:0]   in_target,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          cpu_run,
    output logic          err
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    state_e      state;
    logic [31:0] pc;
    logic [31:0] word;
    logic        illegal;
    logic        range_bad;
    logic        accept;

    // Ready depends only on registered state so there is no input-to-ready path.
    assign in_ready = (state == ST_LOAD) && (count < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign pc       = {{(32 - AW - 3){1'b0}}, count, 2'b00};

    instr_pack u_pack (
        .kind      (in_kind),
        .alu       (in_alu),
        .rs        (in_rs),
        .rt        (in_rt),
        .rd        (in_rd),
        .imm       (in_imm),
        .target    (in_target),
        .pc        (pc),
        .word      (word),
        .illegal   (illegal),
        .range_bad (range_bad)
    );

    // Session FSM, slot counter and registered memory write port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0000_0000;
            count      <= '0;
            cpu_run    <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_LOAD;
                        count   <= '0;
                        err     <= 1'b0;
                        cpu_run <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (illegal || range_bad) begin
                            err <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= count[AW-1:0];
                            imem_wdata <= word;
                            count      <= count + 1'b1;
                        end
                    end
                    if (finish) begin
                        state   <= ST_DONE;
                        cpu_run <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (DEPTH=4 so the full case is short).
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset_n, start, finish, in_valid;
    logic        in_ready;
    logic [2:0]  in_kind, in_alu;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [31:0] in_target;
    logic        imem_we;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  count;
    logic        cpu_run, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_loader #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_alu(in_alu),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .cpu_run(cpu_run), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] k, input logic [2:0] a, input logic [4:0] s,
                           input logic [4:0] t, input logic [4:0] d, input logic [15:0] i,
                           input logic [31:0] tg);
        in_kind = k; in_alu = a; in_rs = s; in_rt = t; in_rd = d; in_imm = i; in_target = tg;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; tick(); finish = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick(); tick();
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", imem_we); end
        checks++; if (imem_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", imem_wdata); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if ({in_ready, cpu_run, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {in_ready, cpu_run, err}); end
        reset_n = 1'b1; tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %0b expected 0", in_ready); end
    endtask

    task automatic test_add();
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %0b expected 1", in_ready); end
        set_req(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL add_we: got %0b expected 1", imem_we); end
        checks++; if (imem_addr !== 2'd0) begin errors++; $display("FAIL add_addr: got %0d expected 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h00221820) begin errors++; $display("FAIL add_wdata: got %h expected 00221820", imem_wdata); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL add_count: got %0d expected 1", count); end
        tick();
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL add_we_drop: got %0b expected 0", imem_we); end
        pulse_finish();
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++; if ({count, cpu_run} !== 4'b0000) begin errors++; $display("FAIL b2b_restart: got %b expected 0000", {count, cpu_run}); end
        in_valid = 1'b1;
        set_req(3'd1, 3'd0, 5'd0, 5'd2, 5'd0, 16'h0050, 32'h0); tick();
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd0, 32'h8C020050}) begin errors++; $display("FAIL lw_word: got we=%0b addr=%0d data=%h expected 1/0/8c020050", imem_we, imem_addr, imem_wdata); end
        set_req(3'd2, 3'd0, 5'd0, 5'd2, 5'd0, 16'h0004, 32'h0); tick();
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd1, 32'hAC020004}) begin errors++; $display("FAIL sw_word: got we=%0b addr=%0d data=%h expected 1/1/ac020004", imem_we, imem_addr, imem_wdata); end
        set_req(3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h00000040); tick();
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd2, 32'h08000010}) begin errors++; $display("FAIL j_word: got we=%0b addr=%0d data=%h expected 1/2/08000010", imem_we, imem_addr, imem_wdata); end
        set_req(3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'h0000, 32'h00000000); tick();
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd3, 32'h1022FFFC}) begin errors++; $display("FAIL beq_back: got we=%0b addr=%0d data=%h expected 1/3/1022fffc", imem_we, imem_addr, imem_wdata); end
        checks++; if ({count, in_ready} !== {3'd4, 1'b0}) begin errors++; $display("FAIL full_ready: got count=%0d ready=%0b expected 4/0", count, in_ready); end
        set_req(3'd0, 3'd1, 5'd4, 5'd5, 5'd6, 16'h0000, 32'h0); tick(); tick();
        checks++; if ({imem_we, count} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_hold: got we=%0b count=%0d expected 0/4", imem_we, count); end
        pulse_finish();
        checks++; if ({cpu_run, count, in_ready} !== {1'b1, 3'd4, 1'b0}) begin errors++; $display("FAIL full_done: got run=%0b count=%0d ready=%0b expected 1/4/0", cpu_run, count, in_ready); end
        tick();
        checks++; if ({imem_we, cpu_run} !== 2'b01) begin errors++; $display("FAIL done_nowrite: got we=%0b run=%0b expected 0/1", imem_we, cpu_run); end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        pulse_start();
        set_req(3'd6, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        checks++; if ({imem_we, err, count} !== {1'b0, 1'b1, 3'd0}) begin errors++; $display("FAIL bad_kind: got we=%0b err=%0b count=%0d expected 0/1/0", imem_we, err, count); end
        pulse_start();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL start_in_load: got err=%0b expected 1", err); end
        pulse_finish(); pulse_start();
        set_req(3'd0, 3'd5, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        checks++; if ({imem_we, err, count} !== {1'b0, 1'b1, 3'd0}) begin errors++; $display("FAIL bad_alu: got we=%0b err=%0b count=%0d expected 0/1/0", imem_we, err, count); end
        pulse_finish(); pulse_start();
        set_req(3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'h0000, 32'h00040000); in_valid = 1'b1; tick(); in_valid = 1'b0;
`ifdef INSTR_LOADER_RANGE_CHECK_EN
        checks++; if ({imem_we, err, count} !== {1'b0, 1'b1, 3'd0}) begin errors++; $display("FAIL beq_range: got we=%0b err=%0b count=%0d expected 0/1/0", imem_we, err, count); end
`else
        checks++; if ({imem_we, err, count, imem_wdata} !== {1'b1, 1'b0, 3'd1, 32'h1022FFFF}) begin errors++; $display("FAIL beq_trunc: got we=%0b err=%0b count=%0d data=%h expected 1/0/1/1022ffff", imem_we, err, count, imem_wdata); end
`endif
        pulse_finish();
    endtask

    task automatic test_finish_same_cycle();
        pulse_start();
        set_req(3'd0, 3'd4, 5'd7, 5'd8, 5'd9, 16'h0000, 32'h0); in_valid = 1'b1; finish = 1'b1;
        tick(); in_valid = 1'b0; finish = 1'b0;
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd0, 32'h00E8482A}) begin errors++; $display("FAIL fin_write: got we=%0b addr=%0d data=%h expected 1/0/00e8482a", imem_we, imem_addr, imem_wdata); end
        checks++; if ({cpu_run, in_ready, count} !== {1'b1, 1'b0, 3'd1}) begin errors++; $display("FAIL fin_done: got run=%0b ready=%0b count=%0d expected 1/0/1", cpu_run, in_ready, count); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        in_valid = 1'b1;
        set_req(3'd0, 3'd2, 5'd1, 5'd1, 5'd1, 16'h0000, 32'h0); tick();
        set_req(3'd4, 3'd0, 5'd3, 5'd4, 5'd0, 16'h1234, 32'h0); tick();
        checks++; if ({imem_addr, imem_wdata} !== {2'd1, 32'h20641234}) begin errors++; $display("FAIL addi_word: got addr=%0d data=%h expected 1/20641234", imem_addr, imem_wdata); end
        set_req(3'd7, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h0); tick();
        set_req(3'd1, 3'd0, 5'd1, 5'd1, 5'd0, 16'h0008, 32'h0); reset_n = 1'b0; tick();
        in_valid = 1'b0; reset_n = 1'b1;
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b0, 2'd0, 32'h0}) begin errors++; $display("FAIL mid_rst_write: got we=%0b addr=%0d data=%h expected 0/0/0", imem_we, imem_addr, imem_wdata); end
        checks++; if ({count, cpu_run, err, in_ready} !== 6'b000000) begin errors++; $display("FAIL mid_rst_state: got count=%0d run=%0b err=%0b ready=%0b expected 0/0/0/0", count, cpu_run, err, in_ready); end
        tick();
        checks++; if ({in_ready, imem_we} !== 2'b00) begin errors++; $display("FAIL mid_rst_idle: got ready=%0b we=%0b expected 0/0", in_ready, imem_we); end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        set_req(3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0);
        test_reset();
        test_add();
        test_back_to_back();
        test_illegal();
        test_finish_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
